if_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline. It owns the fetch PC and drives the instruction memory with a request/ready handshake. It writes the IF/ID pipeline register (`Instruction`, `PC`) that the decode stage reads, and it applies the redirects the decode stage resolves: jump, jump-register, and taken branch. The pipeline has no delay slot, so the wrong-path fetch is squashed and a NOP bubble is inserted in its place.

---
 rtl/if_pkg.sv | 17 +
 rtl/if_stage_if_id_reg.sv | 34 +++
 rtl/if_stage.sv | 160 ++++++++++++++++
 tb/tb_if_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states,
// decode PCSrc encodings and the default bubble instruction.
package if_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DISCARD = 2'd1,
        ST_HOLD    = 2'd2
    } if_state_t;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_J   = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: hold on stall, load a fetched word, or
// insert a bubble (NOP with the PC left unchanged).
module if_id_reg
    import if_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    // Stall has priority; a load beats a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (!stall) begin
            if (load) begin
                instr <= load_instr;
                pc    <= load_pc;
            end else if (bubble) begin
                instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs the single-outstanding
// request handshake to instruction memory and applies decode redirects.
// Optional feature macro: IF_PERF_CNT_EN adds RedirectCnt / BubbleCnt.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic [1:0]  Jump,
    input  logic        Branch,
    input  logic        BranchCond,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] JrTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemRdy,
    input  logic [31:0] IMemData,
    output logic [31:0] Instruction,
    output logic [31:0] PC
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] RedirectCnt,
    output logic [31:0] BubbleCnt
`endif
);

    if_state_t   state_reg, state_next;
    logic [31:0] pcf_reg, pcf_next;
    logic [31:0] hold_instr_reg, hold_instr_next;
    logic [31:0] redir_pc_reg, redir_pc_next;

    logic        redirect;
    logic [31:0] target;
    logic        mem_req;
    logic        ifid_load;
    logic        ifid_bubble;
    logic [31:0] ifid_instr;

    // Redirect decode; a stalled decode stage must not steer the fetch.
    always_comb begin
        redirect = !Stall && ((Jump != PCSRC_SEQ) || (Branch && BranchCond));
        target   = ((Jump == PCSRC_JR) ? JrTarget : JumpTarget) & 32'hFFFF_FFFC;
    end

    // Fetch state and PC registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_FETCH;
            pcf_reg        <= RESET_PC;
            hold_instr_reg <= NOP_INSTR;
            redir_pc_reg   <= RESET_PC;
        end else begin
            state_reg      <= state_next;
            pcf_reg        <= pcf_next;
            hold_instr_reg <= hold_instr_next;
            redir_pc_reg   <= redir_pc_next;
        end
    end

    // Next-state, PC update and IF/ID load selection.
    always_comb begin
        state_next      = state_reg;
        pcf_next        = pcf_reg;
        hold_instr_next = hold_instr_reg;
        redir_pc_next   = redir_pc_reg;
        mem_req         = 1'b1;
        ifid_load       = 1'b0;
        ifid_instr      = IMemData;
        case (state_reg)
            ST_FETCH: begin
                if (IMemRdy) begin
                    if (redirect) begin
                        pcf_next = target;
                    end else if (!Stall) begin
                        ifid_load = 1'b1;
                        pcf_next  = pcf_reg + 32'd4;
                    end else begin
                        hold_instr_next = IMemData;
                        state_next      = ST_HOLD;
                    end
                end else if (redirect) begin
                    redir_pc_next = target;
                    state_next    = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                // The squashed request still has to complete; the newest
                // redirect seen while waiting decides where fetch resumes.
                if (redirect) begin
                    redir_pc_next = target;
                end
                if (IMemRdy) begin
                    pcf_next   = redirect ? target : redir_pc_reg;
                    state_next = ST_FETCH;
                end
            end
            ST_HOLD: begin
                mem_req    = 1'b0;
                ifid_instr = hold_instr_reg;
                if (!Stall) begin
                    ifid_load  = 1'b1;
                    pcf_next   = pcf_reg + 32'd4;
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
        ifid_bubble = !Stall && !ifid_load;
    end

    // Request drops immediately with reset so a pending access is abandoned.
    always_comb begin
        IMemReq  = mem_req && !reset;
        IMemAddr = pcf_reg;
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .reset     (reset),
        .stall     (Stall),
        .load      (ifid_load),
        .bubble    (ifid_bubble),
        .load_instr(ifid_instr),
        .load_pc   (pcf_reg),
        .instr     (Instruction),
        .pc        (PC)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] redirect_cnt_reg;
    logic [31:0] bubble_cnt_reg;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_cnt_reg <= '0;
            bubble_cnt_reg   <= '0;
        end else begin
            if (redirect) begin
                redirect_cnt_reg <= redirect_cnt_reg + 32'd1;
            end
            if (ifid_bubble) begin
                bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
            end
        end
    end

    assign RedirectCnt = redirect_cnt_reg;
    assign BubbleCnt   = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized
// run against a request-level reference model (one outstanding request
// with a drop flag, an optional buffered word, and the IF/ID contents).
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Stall = 1'b0;
    logic [1:0]  Jump = 2'b00;
    logic        Branch = 1'b0;
    logic        BranchCond = 1'b0;
    logic [31:0] JumpTarget = '0;
    logic [31:0] JrTarget = '0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemRdy = 1'b0;
    logic [31:0] IMemData = '0;
    logic [31:0] Instruction;
    logic [31:0] PC;
`ifdef IF_PERF_CNT_EN
    logic [31:0] RedirectCnt;
    logic [31:0] BubbleCnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_fa, m_tgt, m_buf, m_instr, m_pc;
    logic        m_held, m_drop;
    logic [31:0] m_redir_cnt, m_bubble_cnt;

    always #5 clk = ~clk;

    if_stage dut (
        .clk        (clk),
        .reset      (reset),
        .Stall      (Stall),
        .Jump       (Jump),
        .Branch     (Branch),
        .BranchCond (BranchCond),
        .JumpTarget (JumpTarget),
        .JrTarget   (JrTarget),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemRdy    (IMemRdy),
        .IMemData   (IMemData),
        .Instruction(Instruction),
        .PC         (PC)
`ifdef IF_PERF_CNT_EN
        ,
        .RedirectCnt(RedirectCnt),
        .BubbleCnt  (BubbleCnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        m_fa = RST_PC; m_tgt = '0; m_buf = '0; m_instr = NOP; m_pc = '0;
        m_held = 1'b0; m_drop = 1'b0; m_redir_cnt = '0; m_bubble_cnt = '0;
    endtask

    // Drive one cycle of inputs at a negedge, advance the model, wait for the next negedge.
    task automatic step(input logic st, input logic [1:0] jp, input logic br, input logic bc,
                        input logic [31:0] jt, input logic [31:0] jrt, input logic rdy);
        logic        redir, loaded, rdy_d;
        logic [31:0] tgt;
        Stall = st; Jump = jp; Branch = br; BranchCond = bc; JumpTarget = jt; JrTarget = jrt;
        rdy_d = rdy && IMemReq;
        IMemRdy = rdy_d;
        IMemData = mem_word(IMemAddr);
        redir = !st && (jp != 2'b00 || (br && bc));
        tgt = (jp == 2'b10) ? jrt : jt;
        tgt[1:0] = 2'b00;
        loaded = 1'b0;
        if (m_held) begin
            if (!st) begin
                m_instr = m_buf; m_pc = m_fa; m_fa = m_fa + 32'd4; m_held = 1'b0; loaded = 1'b1;
            end
        end else begin
            if (redir) begin m_drop = 1'b1; m_tgt = tgt; end
            if (rdy_d) begin
                if (m_drop) begin
                    m_fa = m_tgt; m_drop = 1'b0;
                end else if (st) begin
                    m_buf = mem_word(m_fa); m_held = 1'b1;
                end else begin
                    m_instr = mem_word(m_fa); m_pc = m_fa; m_fa = m_fa + 32'd4; loaded = 1'b1;
                end
            end
        end
        if (!st && !loaded) begin m_instr = NOP; m_bubble_cnt = m_bubble_cnt + 32'd1; end
        if (redir) m_redir_cnt = m_redir_cnt + 32'd1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL reset_req got %b expected 0", IMemReq); end
        checks++; if (Instruction !== NOP) begin errors++; $display("FAIL reset_instr got %h expected %h", Instruction, NOP); end
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h expected 0", PC); end
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (IMemReq !== 1'b1) begin errors++; $display("FAIL release_req got %b expected 1", IMemReq); end
        checks++; if (IMemAddr !== RST_PC) begin errors++; $display("FAIL release_addr got %h expected %h", IMemAddr, RST_PC); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = RST_PC + 32'(4 * i);
            checks++; if (IMemAddr !== a) begin errors++; $display("FAIL seq_addr[%0d] got %h expected %h", i, IMemAddr, a); end
            step(0, 2'b00, 0, 0, '0, '0, 1);
            checks++; if (PC !== a) begin errors++; $display("FAIL seq_pc[%0d] got %h expected %h", i, PC, a); end
            checks++; if (Instruction !== mem_word(a)) begin errors++; $display("FAIL seq_instr[%0d] got %h expected %h", i, Instruction, mem_word(a)); end
        end
    endtask

    task automatic test_jump();
        step(0, 2'b01, 0, 0, 32'h0040_0100, '0, 1);
        checks++; if (Instruction !== NOP) begin errors++; $display("FAIL jump_bubble got %h expected %h", Instruction, NOP); end
        checks++; if (IMemAddr !== 32'h0040_0100) begin errors++; $display("FAIL jump_addr got %h expected 00400100", IMemAddr); end
        step(0, 2'b00, 0, 0, '0, '0, 1);
        checks++; if (PC !== 32'h0040_0100) begin errors++; $display("FAIL jump_pc got %h expected 00400100", PC); end
        checks++; if (Instruction !== mem_word(32'h0040_0100)) begin errors++; $display("FAIL jump_instr got %h expected %h", Instruction, mem_word(32'h0040_0100)); end
    endtask

    task automatic test_branch_latency();
        checks++; if (IMemAddr !== 32'h0040_0104) begin errors++; $display("FAIL br_start_addr got %h expected 00400104", IMemAddr); end
        step(0, 2'b00, 0, 0, '0, '0, 0);
        step(0, 2'b00, 1, 1, 32'h0040_0200, '0, 0);
        checks++; if (IMemAddr !== 32'h0040_0104) begin errors++; $display("FAIL br_hold_addr1 got %h expected 00400104", IMemAddr); end
        checks++; if (Instruction !== NOP) begin errors++; $display("FAIL br_bubble got %h expected %h", Instruction, NOP); end
        step(0, 2'b00, 0, 0, '0, '0, 0);
        checks++; if (IMemAddr !== 32'h0040_0104) begin errors++; $display("FAIL br_hold_addr2 got %h expected 00400104", IMemAddr); end
        step(0, 2'b00, 0, 0, '0, '0, 1);
        checks++; if (Instruction !== NOP) begin errors++; $display("FAIL br_drop got %h expected %h", Instruction, NOP); end
        checks++; if (PC !== 32'h0040_0100) begin errors++; $display("FAIL br_drop_pc got %h expected 00400100", PC); end
        checks++; if (IMemAddr !== 32'h0040_0200) begin errors++; $display("FAIL br_target_addr got %h expected 00400200", IMemAddr); end
        step(0, 2'b00, 0, 0, '0, '0, 1);
        checks++; if (PC !== 32'h0040_0200) begin errors++; $display("FAIL br_target_pc got %h expected 00400200", PC); end
        checks++; if (Instruction !== mem_word(32'h0040_0200)) begin errors++; $display("FAIL br_target_instr got %h expected %h", Instruction, mem_word(32'h0040_0200)); end
    endtask

    task automatic test_stall_hold();
        for (int i = 0; i < 4; i++) begin
            step(1, 2'b00, 0, 0, '0, '0, 1);
            checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL hold_req[%0d] got %b expected 0", i, IMemReq); end
            checks++; if (PC !== 32'h0040_0200 || Instruction !== mem_word(32'h0040_0200)) begin
                errors++; $display("FAIL hold_ifid[%0d] got %h/%h expected 00400200/%h", i, PC, Instruction, mem_word(32'h0040_0200));
            end
        end
        step(0, 2'b00, 0, 0, '0, '0, 1);
        checks++; if (PC !== 32'h0040_0204) begin errors++; $display("FAIL unhold_pc got %h expected 00400204", PC); end
        checks++; if (Instruction !== mem_word(32'h0040_0204)) begin errors++; $display("FAIL unhold_instr got %h expected %h", Instruction, mem_word(32'h0040_0204)); end
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0040_0208) begin errors++; $display("FAIL unhold_addr got %b/%h expected 1/00400208", IMemReq, IMemAddr); end
        step(0, 2'b00, 0, 0, '0, '0, 1);
        checks++; if (PC !== 32'h0040_0208) begin errors++; $display("FAIL after_hold_pc got %h expected 00400208", PC); end
    endtask

    task automatic test_jr();
        step(1, 2'b10, 0, 0, '0, 32'h0040_0013, 0);
        checks++; if (IMemAddr !== 32'h0040_020C) begin errors++; $display("FAIL jr_stalled_addr got %h expected 0040020c", IMemAddr); end
        checks++; if (PC !== 32'h0040_0208) begin errors++; $display("FAIL jr_stalled_pc got %h expected 00400208", PC); end
        step(0, 2'b10, 0, 0, '0, 32'h0040_0013, 1);
        checks++; if (IMemAddr !== 32'h0040_0010) begin errors++; $display("FAIL jr_addr got %h expected 00400010", IMemAddr); end
        checks++; if (Instruction !== NOP) begin errors++; $display("FAIL jr_bubble got %h expected %h", Instruction, NOP); end
        step(0, 2'b00, 0, 0, '0, '0, 1);
        checks++; if (PC !== 32'h0040_0010) begin errors++; $display("FAIL jr_pc got %h expected 00400010", PC); end
        checks++; if (Instruction !== mem_word(32'h0040_0010)) begin errors++; $display("FAIL jr_instr got %h expected %h", Instruction, mem_word(32'h0040_0010)); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            logic st, br, bc, rdy;
            logic [1:0]  jp;
            logic [31:0] jt, jrt;
            int r;
            st = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            jp = 2'b00; br = 1'b0; bc = 1'b0;
            if (!m_held) begin
                r = $urandom_range(0, 11);
                if (r == 0) jp = 2'b01;
                else if (r == 1) jp = 2'b10;
                else if (r == 2) jp = 2'b11;
                else if (r <= 5) begin br = 1'b1; bc = ($urandom_range(0, 1) == 1); end
            end
            jt  = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : (32'h0040_0000 | 32'($urandom_range(0, 1023)));
            jrt = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : (32'h0040_0000 | 32'($urandom_range(0, 1023)));
            step(st, jp, br, bc, jt, jrt, rdy);
            checks++; if (Instruction !== m_instr || PC !== m_pc) begin
                errors++; $display("FAIL rand_ifid[%0d] got %h/%h expected %h/%h", n, PC, Instruction, m_pc, m_instr);
            end
            checks++; if (IMemReq !== !m_held || (!m_held && IMemAddr !== m_fa)) begin
                errors++; $display("FAIL rand_fetch[%0d] got %b/%h expected %b/%h", n, IMemReq, IMemAddr, !m_held, m_fa);
            end
`ifdef IF_PERF_CNT_EN
            checks++; if (RedirectCnt !== m_redir_cnt || BubbleCnt !== m_bubble_cnt) begin
                errors++; $display("FAIL rand_cnt[%0d] got %0d/%0d expected %0d/%0d", n, RedirectCnt, BubbleCnt, m_redir_cnt, m_bubble_cnt);
            end
`endif
        end
    endtask

    task automatic test_reset_mid_request();
        step(0, 2'b00, 0, 0, '0, '0, 0);
        step(0, 2'b00, 0, 0, '0, '0, 0);
        checks++; if (IMemReq !== 1'b1) begin errors++; $display("FAIL pre_reset_req got %b expected 1", IMemReq); end
        #2 reset = 1'b1;
        #1;
        checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL async_reset_req got %b expected 0", IMemReq); end
        checks++; if (Instruction !== NOP || PC !== 32'h0) begin errors++; $display("FAIL async_reset_ifid got %h/%h expected 0/%h", PC, Instruction, NOP); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== RST_PC) begin errors++; $display("FAIL restart_fetch got %b/%h expected 1/%h", IMemReq, IMemAddr, RST_PC); end
`ifdef IF_PERF_CNT_EN
        checks++; if (RedirectCnt !== 32'h0 || BubbleCnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got %0d/%0d expected 0/0", RedirectCnt, BubbleCnt); end
`endif
        step(0, 2'b00, 0, 0, '0, '0, 1);
        checks++; if (PC !== RST_PC || Instruction !== mem_word(RST_PC)) begin
            errors++; $display("FAIL restart_ifid got %h/%h expected %h/%h", PC, Instruction, RST_PC, mem_word(RST_PC));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_jump();
        test_branch_latency();
        test_stall_hold();
        test_jr();
        test_random();
        test_reset_mid_request();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
